// File: rtl/conv_encoder_framer_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and its Viterbi decoder:
// constraint-length type, generator table, framing FSM states and the parity function.
package conv_encoder_framer_pkg;

  typedef logic [2:0] k_t;

  localparam k_t K_MIN = 3'd3;
  localparam k_t K_MAX = 3'd6;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  // {G0, G1} in octal, the MSB of each tap set touches the current bit.
  localparam logic [11:0] GEN_TABLE [K_MIN:K_MAX] = '{
    {6'o07, 6'o05},
    {6'o17, 6'o15},
    {6'o23, 6'o35},
    {6'o53, 6'o75}
  };

  function automatic k_t k_sanitize(input k_t k);
    return (k >= K_MIN && k <= K_MAX) ? k : K_MIN;
  endfunction

  // window[0] is the current bit, window[i] the bit accepted i steps earlier.
  function automatic logic [1:0] conv_parity(input logic [5:0] window, input k_t k);
    logic [11:0] gens;
    logic [5:0]  g0;
    logic [5:0]  g1;
    logic [2:0]  tap;
    logic [1:0]  p;
    k_t          ks;
    ks   = k_sanitize(k);
    gens = GEN_TABLE[ks];
    g0   = gens[11:6];
    g1   = gens[5:0];
    p    = 2'b00;
    for (int i = 0; i < 6; i++) begin
      if (3'(i) < ks) begin
        tap  = ks - 3'd1 - 3'(i);
        p[1] = p[1] ^ (window[i] & g0[tap]);
        p[0] = p[0] ^ (window[i] & g1[tap]);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/conv_encoder_framer.sv
// Rate-1/2 convolutional encoder with frame handling and optional zero tail so the
// trellis terminates in state 0; one 2-bit symbol per cycle through a single output slot.
module conv_encoder_framer
  import conv_encoder_framer_pkg::*;
#(
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] choose_constraint_length,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] encoded_bits,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  state_t      state;
  k_t          k_q;
  logic [4:0]  hist;
  logic [2:0]  tail_cnt;
  logic [1:0]  sym_p1;
  logic        vld_p1;
  logic        last_p1;
  logic        rdy_en;

  logic        slot_free;
  logic        accept;
  logic        tail_go;
  logic        emit;
  logic        last_done;
  logic        shift_bit;
  k_t          k_cur;
  logic [1:0]  sym_next;

  assign slot_free = !vld_p1 || out_ready;
  // rdy_en keeps in_ready low for the first cycle after reset release.
  assign in_ready  = rdy_en && slot_free && (state != TAIL) && !(vld_p1 && last_p1);
  assign accept    = in_valid && in_ready;
  assign tail_go   = (state == TAIL) && slot_free && (tail_cnt != 3'd0);
  assign emit      = accept || tail_go;
  assign last_done = vld_p1 && last_p1 && out_ready;
  assign shift_bit = accept ? in_bit : 1'b0;
  assign k_cur     = (state == IDLE) ? k_sanitize(choose_constraint_length) : k_q;
  assign sym_next  = conv_parity({hist, shift_bit}, k_cur);

  assign encoded_bits = sym_p1;
  assign out_valid    = vld_p1;
  assign out_last     = last_p1;
  assign busy         = (state != IDLE);

  // ---- p0 -> p1: encode accepted or tail bit into the output slot ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k_q      <= K_MIN;
      hist     <= '0;
      tail_cnt <= '0;
      sym_p1   <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (slot_free) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
      if (emit) begin
        sym_p1 <= sym_next;
        vld_p1 <= 1'b1;
        hist   <= {hist[3:0], shift_bit};
      end
      case (state)
        IDLE: begin
          if (accept) begin
            k_q <= k_cur;
            if (!in_last) begin
              state <= DATA;
            end else if (TAIL_EN) begin
              state    <= TAIL;
              tail_cnt <= k_cur - 3'd1;
            end else begin
              last_p1 <= 1'b1;
              hist    <= '0;
            end
          end
        end
        DATA: begin
          if (accept && in_last) begin
            if (TAIL_EN) begin
              state    <= TAIL;
              tail_cnt <= k_q - 3'd1;
            end else begin
              last_p1 <= 1'b1;
            end
          end else if (!TAIL_EN && last_done) begin
            state <= IDLE;
            hist  <= '0;
          end
        end
        TAIL: begin
          if (tail_go) begin
            tail_cnt <= tail_cnt - 3'd1;
            if (tail_cnt == 3'd1) last_p1 <= 1'b1;
          end
          if (last_done) begin
            state <= IDLE;
            hist  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_encoder_framer.md
# conv_encoder_framer

Rate-1/2 convolutional encoder with frame handling, sitting directly upstream of the Viterbi decoder in the encoder/decoder chain. It accepts a serial bit stream with valid/ready/last framing and encodes each bit with the generator pair for the selected constraint length K = 3..6. After each frame it appends K-1 zero tail bits so the trellis terminates in state 0, and emits one 2-bit symbol per cycle to the channel/decoder side.

## Interface
- TAIL_EN, 1: 1 = append K-1 zero flush bits per frame; 0 = no tail, frame ends on its last data symbol.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- choose_constraint_length  in  3  K select; sampled only when the first bit of a frame is accepted. Values outside 3..6 are treated as 3.
- in_bit  in  1  data bit.
- in_valid  in  1  in_bit is valid.
- in_last  in  1  in_bit is the final data bit of the frame.
- in_ready  out  1  block accepts in_bit this cycle.
- encoded_bits  out  2  [1] = G0 parity, [0] = G1 parity.
- out_valid  out  1  encoded_bits is valid.
- out_last  out  1  final symbol of the frame.
- out_ready  in  1  downstream accepts the symbol.
- busy  out  1  high while not in IDLE.

## Operation
- Generators (octal, MSB taps the current bit):
  - K=3: 7,5
  - K=4: 17,15
  - K=5: 23,35
  - K=6: 53,75
- Window: w[0] = current bit; w[i] = bit accepted i steps earlier, for i = 1..K-1.
- Parity: p = XOR over i of g[K-1-i] & w[i].
- History is a 5-bit shift register. It clears on reset and on entry to IDLE. Bits beyond K-1 are ignored.
- K is latched into k_q at the first accepted bit of a frame and held until the frame's out_last symbol is accepted.
- FSM states:
  - IDLE: first accepted bit latches K and goes to DATA. If that bit also has in_last, go to TAIL, or to IDLE when TAIL_EN=0.
  - DATA: each accepted bit is encoded and shifted in. An accepted bit with in_last goes to TAIL, loading tail_cnt = k_q-1. When TAIL_EN=0 it goes to IDLE once its symbol is accepted.
  - TAIL: in_ready = 0. Each free output slot encodes a zero bit and decrements tail_cnt. The symbol produced at tail_cnt = 1 carries out_last. Go to IDLE when that symbol is accepted.
- Only one frame is in flight. in_valid during TAIL is held off, not dropped.

## Timing
- Output register is a single slot.
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && state != TAIL && !(out_valid && out_last).
- Latency: a bit accepted at edge t drives encoded_bits/out_valid from t to t+1 (one cycle). Full throughput is one symbol per cycle under continuous out_ready.
- Backpressure: while out_valid && !out_ready, encoded_bits, out_last and the history stay stable and no input is accepted.
- Reset values: encoded_bits = 00, out_valid = 0, out_last = 0, in_ready = 0, busy = 0, FSM = IDLE, history = 0, tail_cnt = 0. in_ready rises the cycle after rst_n deasserts.
- Reset mid-frame: all of the above takes effect immediately (asynchronous). The partial frame is discarded with no out_last.
- Frame symbol count is N + (K-1) when TAIL_EN=1, and N when TAIL_EN=0.

## Structure
- Shared package (used with the decoder) holds:
  - k_t (3-bit)
  - K_MIN = 3, K_MAX = 6
  - the generator table, indexed by K
  - state enum {IDLE, DATA, TAIL}
  - pure function conv_parity(window, k) returning 2 bits
- No sub-module: the FSM, history register and output slot live in one module. Parity comes from the package function.

## Test plan
- K=3, bits 1,0,1,1 (last on 4th), out_ready=1 -> symbols 11,10,00,01,01,11; out_last only on the 6th; busy low after.
- K=3, single bit 1 with in_last -> 11,10,11; out_last on the 3rd. Same frame with TAIL_EN=0 -> single 11 with out_last.
- out_ready toggled pseudo-randomly on a 32-bit frame, K=5 -> symbol stream identical to the out_ready=1 run; no stall-cycle changes in encoded_bits.
- choose_constraint_length=7, then 2 -> both encode as K=3 (two tail symbols). A K change mid-frame is ignored until the next frame.
- Back-to-back frames with in_valid held high -> in_ready low for all K-1 tail cycles. The second frame's first symbol equals a fresh-state encode (history cleared).
- rst_n pulsed low mid-DATA -> out_valid=0 asynchronously; the next frame encodes from zero state with correct values.
